bin_load_responder: RTL

- Engine-side endpoint of the bin load/update channel: receives the clause rows and variable states that the load/update controller pushes into the SAT engine.
- Holds them as the engine's local bin image and serves clause reads and learnt-clause appends from the engine core.
- Answers the controller's one-hot get_lit_cells strobes with the learnt clauses, and returns the live variable states.

---
 rtl/bin_load_responder.sv | 121 ++++++++++++
 1 files changed

// File: rtl/bin_load_responder.sv
// bin_load_responder: engine-side bin image fed by the load/update channel; optional BIN_RESP_LEARNT_CLEAR_EN zeroes learnt rows after unload.
module bin_load_responder #(
  parameter int NUM_CLAUSES_A_BIN = 24,
  parameter int NUM_VARS_A_BIN = 24,
  parameter int WIDTH_BIN_CLAUSES = 48,
  parameter int WIDTH_VAR_STATES = 30,
  parameter int ROW_IDX_W = 5
) (
  input  logic clk,
  input  logic rst,
  input  logic [NUM_CLAUSES_A_BIN-1:0] set_lit_cells_i,
  input  logic [WIDTH_BIN_CLAUSES-1:0] clauses_i,
  input  logic clauses_valid_i,
  input  logic [WIDTH_VAR_STATES*NUM_VARS_A_BIN-1:0] var_state_i,
  input  logic [NUM_VARS_A_BIN-1:0] var_state_valid_i,
  input  logic [NUM_CLAUSES_A_BIN/2-1:0] get_lit_cells_i,
  output logic [WIDTH_BIN_CLAUSES-1:0] learnt_clauses_o,
  output logic learnt_clauses_valid_o,
  output logic [WIDTH_VAR_STATES*NUM_VARS_A_BIN-1:0] var_state_o,
  input  logic eng_rd_en_i,
  input  logic [ROW_IDX_W-1:0] eng_rd_row_i,
  output logic [WIDTH_BIN_CLAUSES-1:0] eng_clause_o,
  output logic eng_clause_valid_o,
  input  logic eng_learnt_wr_i,
  input  logic [WIDTH_BIN_CLAUSES-1:0] eng_learnt_i,
  input  logic [NUM_VARS_A_BIN-1:0] eng_var_wr_i,
  input  logic [WIDTH_VAR_STATES*NUM_VARS_A_BIN-1:0] eng_var_state_i,
  output logic bin_ready_o,
  output logic learnt_full_o,
  output logic load_error_o
);
  localparam int N = NUM_CLAUSES_A_BIN;
  localparam int H = N / 2;
  localparam int NV = NUM_VARS_A_BIN;
  localparam int W = WIDTH_BIN_CLAUSES;
  localparam int V = WIDTH_VAR_STATES;
  localparam int CW = $clog2(H + 1);
`ifdef BIN_RESP_LEARNT_CLEAR_EN
  localparam bit CLR = 1'b1;
`else
  localparam bit CLR = 1'b0;
`endif
  typedef enum logic [1:0] {IDLE, LOAD, READY, UNLOAD} state_t;
  state_t state, state_n;
  logic [W-1:0] rows [N];
  logic [V-1:0] vars [NV];
  logic [N-1:0] row_mask, row_mask_n;
  logic [NV-1:0] var_mask, var_mask_n, var_wr, eng_var;
  logic [CW-1:0] cnt;
  logic busy, reload, enter, loading, row_hot, get_any, get_hot;
  logic clause_wr, serve, fin, append, err, rd_ok, hit;
  logic [W-1:0] sel;
  always_comb begin
    busy = state == READY || state == UNLOAD;
    reload = busy && clauses_valid_i;
    enter = reload || (state == IDLE && (clauses_valid_i || |var_state_valid_i));
    loading = enter || state == LOAD;
    row_hot = |set_lit_cells_i && (set_lit_cells_i & (set_lit_cells_i - 1'b1)) == '0;
    get_any = |get_lit_cells_i;
    get_hot = (get_lit_cells_i & (get_lit_cells_i - 1'b1)) == '0;
    clause_wr = loading && clauses_valid_i && row_hot;
    var_wr = loading ? var_state_valid_i : '0;
    eng_var = (state == READY && !reload) ? eng_var_wr_i : '0;
    serve = busy && !clauses_valid_i && get_any;
    fin = serve && get_lit_cells_i[H-1];
    append = state == READY && !reload && eng_learnt_wr_i && cnt < CW'(H);
    rd_ok = eng_rd_en_i && state == READY && eng_rd_row_i < ROW_IDX_W'(N);
    err = (loading && clauses_valid_i && !row_hot) || reload || (!busy && get_any) || (serve && !get_hot);
    row_mask_n = (enter ? '0 : row_mask) | (clause_wr ? set_lit_cells_i : '0);
    var_mask_n = (enter ? '0 : var_mask) | var_wr;
    state_n = enter ? LOAD :
              (state == LOAD && &row_mask_n && &var_mask_n) ? READY :
              fin ? IDLE :
              serve ? UNLOAD : state;
    hit = 1'b0;
    sel = '0;
    for (int j = 0; j < H; j++)
      if (get_lit_cells_i[j] && CW'(j) < cnt) begin
        hit = 1'b1;
        sel = sel | rows[H+j];
      end
  end
  // learnt slot j lives at row H+j; cnt is the next free slot
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      row_mask <= '0;
      var_mask <= '0;
      cnt <= '0;
      load_error_o <= 1'b0;
      eng_clause_o <= '0;
      eng_clause_valid_o <= 1'b0;
      learnt_clauses_o <= '0;
      learnt_clauses_valid_o <= 1'b0;
      for (int r = 0; r < N; r++) rows[r] <= '0;
      for (int k = 0; k < NV; k++) vars[k] <= '0;
    end else begin
      state <= state_n;
      row_mask <= row_mask_n;
      var_mask <= var_mask_n;
      load_error_o <= load_error_o | err;
      cnt <= (enter || (fin && CLR)) ? '0 : cnt + CW'(append);
      eng_clause_valid_o <= rd_ok;
      eng_clause_o <= rd_ok ? rows[eng_rd_row_i] : '0;
      learnt_clauses_valid_o <= serve && get_hot && hit;
      learnt_clauses_o <= (serve && get_hot && hit) ? sel : '0;
      for (int r = 0; r < N; r++)
        if (clause_wr && set_lit_cells_i[r]) rows[r] <= clauses_i;
        else if (append && r >= H && CW'(r - H) == cnt) rows[r] <= eng_learnt_i;
        else if (CLR && fin && r >= H) rows[r] <= '0;
      for (int k = 0; k < NV; k++)
        if (var_wr[k]) vars[k] <= var_state_i[k*V +: V];
        else if (eng_var[k]) vars[k] <= eng_var_state_i[k*V +: V];
    end
  end
  assign bin_ready_o = state == READY;
  assign learnt_full_o = cnt == CW'(H);
  for (genvar k = 0; k < NV; k++) begin : g_var
    assign var_state_o[k*V +: V] = vars[k];
  end
endmodule
